// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out shifter.
// Imported by the core and the top.
package piso_pkg;

  localparam int PISO_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/piso_shift_reg_core.sv
// Shift register core: parallel load, left shift, zero fill.
// Written to be reusable for a SIPO variant.
module shift_reg_core
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = {sr_q[WIDTH-2:0], 1'b0};
    if (load_i) begin
      sr_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q;

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register, MSB first.
// A load mid-word replaces the contents immediately.
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] p_in,
  output logic             s_out
);

  if (WIDTH < 2) begin : g_width_chk
    $error("piso_shift_reg: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] sr;

  shift_reg_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .rst_n_i(rst),
    .load_i (load),
    .d_i    (p_in),
    .q_o    (sr)
  );

  assign s_out = sr[WIDTH-1];

  // Tracks whether reset has been seen, so the X check is armed only then.
  logic rst_seen_q;
  logic rst_seen_d;

  always_comb begin
    rst_seen_d = rst_seen_q;
    if (!rst) begin
      rst_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    rst_seen_q <= rst_seen_d;
  end

  a_sout_known: assert property (
    @(posedge clk) rst_seen_q |-> !$isunknown(s_out)
  );

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg at WIDTH 4 and 8.
// Directed cases plus random traffic against a bit-queue model.
module tb_piso_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       load4;
  logic       load8;
  logic [3:0] p4;
  logic [7:0] p8;
  logic       s4;
  logic       s8;

  int total = 0;
  int bad   = 0;

  bit q4[$];
  bit q8[$];

  always #5 clk = ~clk;

  piso_shift_reg #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .load (load4),
    .p_in (p4),
    .s_out(s4)
  );

  piso_shift_reg #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .load (load8),
    .p_in (p8),
    .s_out(s8)
  );

  // Model: the bits still to be sent, MSB first; empty means zeros.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      q4.delete();
      q8.delete();
    end else begin
      if (load4) begin
        q4.delete();
        for (int i = 3; i >= 0; i--) q4.push_back(p4[i]);
      end else if (q4.size() > 0) begin
        void'(q4.pop_front());
      end
      if (load8) begin
        q8.delete();
        for (int i = 7; i >= 0; i--) q8.push_back(p8[i]);
      end else if (q8.size() > 0) begin
        void'(q8.pop_front());
      end
    end
    #1;
  endtask

  function automatic logic exp4();
    return (q4.size() > 0) ? q4[0] : 1'b0;
  endfunction

  function automatic logic exp8();
    return (q8.size() > 0) ? q8[0] : 1'b0;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    load4 = 1'b1;
    load8 = 1'b1;
    p4 = 4'b1111;
    p8 = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (s4 !== 1'b0) begin
        bad++;
        $display("FAIL reset4 cyc%0d got=%b exp=0", i, s4);
      end
      total++;
      if (s8 !== 1'b0) begin
        bad++;
        $display("FAIL reset8 cyc%0d got=%b exp=0", i, s8);
      end
    end
    rst = 1'b1;
    load4 = 1'b0;
    load8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (s4 !== 1'b0) begin
        bad++;
        $display("FAIL reset_release cyc%0d got=%b exp=0", i, s4);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] e;
    e = 8'b1011_0000;
    for (int i = 0; i < 8; i++) begin
      load4 = (i == 0);
      p4 = (i == 0) ? 4'b1011 : 4'($urandom);
      tick();
      total++;
      if (s4 !== e[7-i]) begin
        bad++;
        $display("FAIL basic cyc%0d got=%b exp=%b", i, s4, e[7-i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    e = 7'b1001110;
    for (int i = 0; i < 7; i++) begin
      load4 = (i == 0) || (i == 2);
      p4 = (i == 0) ? 4'b1000 : (i == 2) ? 4'b0111 : 4'($urandom);
      tick();
      total++;
      if (s4 !== e[6-i]) begin
        bad++;
        $display("FAIL b2b cyc%0d got=%b exp=%b", i, s4, e[6-i]);
      end
    end
    load4 = 1'b0;
  endtask

  task automatic test_held_load();
    logic [4:0] msb;
    msb = 5'b10101;
    load4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      p4 = {msb[4-i], 3'($urandom)};
      tick();
      total++;
      if (s4 !== msb[4-i]) begin
        bad++;
        $display("FAIL held cyc%0d got=%b exp=%b", i, s4, msb[4-i]);
      end
    end
    load4 = 1'b0;
  endtask

  task automatic test_reset_mid();
    load4 = 1'b1;
    p4 = 4'b1111;
    tick();
    load4 = 1'b0;
    tick();
    total++;
    if (s4 !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre got=%b exp=1", s4);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (s4 !== 1'b0) begin
        bad++;
        $display("FAIL rstmid cyc%0d got=%b exp=0", i, s4);
      end
      tick();
    end
  endtask

  task automatic test_width8();
    logic [9:0] e;
    e = 10'b1010010100;
    for (int i = 0; i < 10; i++) begin
      load8 = (i == 0);
      p8 = (i == 0) ? 8'hA5 : 8'($urandom);
      tick();
      total++;
      if (s8 !== e[9-i]) begin
        bad++;
        $display("FAIL width8 cyc%0d got=%b exp=%b", i, s8, e[9-i]);
      end
    end
    load8 = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) != 0);
      load4 = ($urandom_range(0, 4) == 0);
      load8 = ($urandom_range(0, 9) == 0);
      p4 = 4'($urandom);
      p8 = 8'($urandom);
      tick();
      total++;
      if (s4 !== exp4()) begin
        bad++;
        $display("FAIL rand4 cyc%0d got=%b exp=%b", i, s4, exp4());
      end
      total++;
      if (s8 !== exp8()) begin
        bad++;
        $display("FAIL rand8 cyc%0d got=%b exp=%b", i, s8, exp8());
      end
    end
    rst = 1'b1;
    load4 = 1'b0;
    load8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    load4 = 1'b0;
    load8 = 1'b0;
    p4 = '0;
    p8 = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_held_load();
    test_reset_mid();
    test_width8();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
